// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding for the stopwatch control stage
// Contents: state_t (IDLE=0, RUN=1, PAUSE=2, LAP=3)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/button_press_detect.sv
// rtl/button_press_detect.sv - 2-FF synchronizer plus rising-edge detect for one raw button
// Ports: clock, reset (sync, active-high), button (raw async level), press (one-cycle pulse)
module button_press_detect (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // All stages reset to 1 so a button held through reset looks like it was
  // already pressed; only a release followed by a new rise produces a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

endmodule

// File: rtl/stopwatch_control.sv
// rtl/stopwatch_control.sv - run/pause/lap FSM with tick prescaler driving the digit counters
// Ports: clock, reset (sync, active-high), start_stop, lap_reset (raw buttons),
//        count (tick), clear (counter clear pulse), hold (display freeze), running, state
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIVISOR = 1_000_000
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   start_stop,
  input  logic   lap_reset,
  output logic   count,
  output logic   clear,
  output logic   hold,
  output logic   running,
  output state_t state
);

  localparam int PRESC_WIDTH = $clog2(TICK_DIVISOR);
  localparam logic [PRESC_WIDTH-1:0] PRESC_MAX = PRESC_WIDTH'(TICK_DIVISOR - 1);

  logic                   ss_press;
  logic                   lr_press;
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] presc_next;
  state_t                 state_next;
  logic                   clear_next;
  logic                   count_next;
  logic                   active;

  button_press_detect u_start_stop (
    .clock  (clock),
    .reset  (reset),
    .button (start_stop),
    .press  (ss_press)
  );

  button_press_detect u_lap_reset (
    .clock  (clock),
    .reset  (reset),
    .button (lap_reset),
    .press  (lr_press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      count   <= 1'b0;
      clear   <= 1'b0;
      hold    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      count   <= count_next;
      clear   <= clear_next;
      hold    <= (state_next == LAP);
      running <= (state_next == RUN) || (state_next == LAP);
    end
  end

  always_comb begin
    state_next = state;
    clear_next = 1'b0;
    // start_stop is tested first in every state, so a coincident lap_reset
    // press is simply dropped.
    unique case (state)
      IDLE: begin
        if (ss_press) begin
          state_next = RUN;
        end else if (lr_press) begin
          clear_next = 1'b1;
        end
      end
      RUN: begin
        if (ss_press) begin
          state_next = PAUSE;
        end else if (lr_press) begin
          state_next = LAP;
        end
      end
      LAP: begin
        if (ss_press) begin
          state_next = PAUSE;
        end else if (lr_press) begin
          state_next = RUN;
        end
      end
      PAUSE: begin
        if (ss_press) begin
          state_next = RUN;
        end else if (lr_press) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Count decisions use the current state, so the terminal tick is still
  // issued on the same edge a pause takes effect.
  always_comb begin
    active     = (state == RUN) || (state == LAP);
    count_next = active && (presc == PRESC_MAX);
    presc_next = presc;
    if (state_next == IDLE) begin
      presc_next = '0;
    end else if (active) begin
      presc_next = (presc == PRESC_MAX) ? '0 : presc + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_control.sv
// tb/tb_stopwatch_control.sv - directed self-checking bench for stopwatch_control (TICK_DIVISOR=4)
module tb_stopwatch_control;
  import stopwatch_pkg::*;

  logic   clock;
  logic   reset;
  logic   start_stop;
  logic   lap_reset;
  logic   count;
  logic   clear;
  logic   hold;
  logic   running;
  state_t state;

  int checks;
  int errors;

  stopwatch_control #(.TICK_DIVISOR(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .count      (count),
    .clear      (clear),
    .hold       (hold),
    .running    (running),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Raise a button, let it reach the FSM (third edge), then release it.
  task automatic press_start();
    start_stop = 1'b1;
    tick(3);
    start_stop = 1'b0;
  endtask

  task automatic press_lap();
    lap_reset = 1'b1;
    tick(3);
    lap_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_stop = 1'b0;
    lap_reset = 1'b0;
    tick(2);
    checks++;
    if ({state, count, clear, hold, running} !== {IDLE, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got state=%0d count=%b clear=%b hold=%b running=%b, want state=0 and all 0",
               state, count, clear, hold, running);
    end
    reset = 1'b0;
    tick(4);
    checks++;
    if (state !== IDLE || count !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got state=%0d count=%b, want 0/0", state, count);
    end
  endtask

  task automatic test_start_hold();
    start_stop = 1'b1;
    tick(2);
    checks++;
    if (state !== IDLE) begin
      errors++;
      $display("FAIL start_latency_edge2: got state=%0d, want 0", state);
    end
    tick(1);
    checks++;
    if (state !== RUN || running !== 1'b1 || hold !== 1'b0) begin
      errors++;
      $display("FAIL start_edge3: got state=%0d running=%b hold=%b, want 1/1/0", state, running, hold);
    end
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 7) start_stop = 1'b0;
      checks++;
      if (state !== RUN || count !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL run_tick k=%0d: got state=%0d count=%b, want state=1 count=%b",
                 k, state, count, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_pause_resume();
    tick(3);
    press_start();
    checks++;
    if (state !== PAUSE || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_entry: got state=%0d running=%b, want 2/0", state, running);
    end
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      checks++;
      if (count !== 1'b0 || state !== PAUSE) begin
        errors++;
        $display("FAIL paused k=%0d: got count=%b state=%0d, want 0/2", k, count, state);
      end
    end
    press_start();
    checks++;
    if (state !== RUN || count !== 1'b0) begin
      errors++;
      $display("FAIL resume_entry: got state=%0d count=%b, want 1/0", state, count);
    end
    tick(1);
    checks++;
    if (count !== 1'b0) begin
      errors++;
      $display("FAIL resume_plus1: got count=%b, want 0", count);
    end
    tick(1);
    checks++;
    if (count !== 1'b1) begin
      errors++;
      $display("FAIL resume_plus2: got count=%b, want 1", count);
    end
  endtask

  task automatic test_lap();
    press_lap();
    checks++;
    if (state !== LAP || hold !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL lap_entry: got state=%0d hold=%b running=%b, want 3/1/1", state, hold, running);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      checks++;
      if (state !== LAP || hold !== 1'b1 || count !== ((k % 4) == 1)) begin
        errors++;
        $display("FAIL lap_tick k=%0d: got state=%0d hold=%b count=%b, want 3/1/%b",
                 k, state, hold, count, (k % 4) == 1);
      end
    end
    press_lap();
    checks++;
    if (state !== RUN || hold !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL lap_exit: got state=%0d hold=%b running=%b, want 1/0/1", state, hold, running);
    end
  endtask

  task automatic test_clear();
    // Pause with the prescaler at 3 so a missing clear-on-IDLE shows up
    // as an early tick after restart.
    tick(2);
    press_start();
    checks++;
    if (state !== PAUSE) begin
      errors++;
      $display("FAIL clear_setup_pause: got state=%0d, want 2", state);
    end
    tick(3);
    lap_reset = 1'b1;
    tick(2);
    checks++;
    if (state !== PAUSE || clear !== 1'b0) begin
      errors++;
      $display("FAIL clear_early: got state=%0d clear=%b, want 2/0", state, clear);
    end
    tick(1);
    checks++;
    if (state !== IDLE || clear !== 1'b1 || running !== 1'b0 || hold !== 1'b0) begin
      errors++;
      $display("FAIL clear_pulse: got state=%0d clear=%b running=%b hold=%b, want 0/1/0/0",
               state, clear, running, hold);
    end
    tick(1);
    checks++;
    if (clear !== 1'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL clear_single_cycle: got clear=%b state=%0d, want 0/0", clear, state);
    end
    tick(3);
    checks++;
    if (clear !== 1'b0) begin
      errors++;
      $display("FAIL clear_held_button: got clear=%b, want 0", clear);
    end
    lap_reset = 1'b0;
    tick(3);
    press_start();
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checks++;
      if (count !== (k == 4)) begin
        errors++;
        $display("FAIL restart_tick k=%0d: got count=%b, want %b", k, count, k == 4);
      end
    end
  endtask

  task automatic test_simultaneous();
    start_stop = 1'b1;
    lap_reset = 1'b1;
    tick(3);
    checks++;
    if (state !== PAUSE || hold !== 1'b0) begin
      errors++;
      $display("FAIL both_pressed: got state=%0d hold=%b, want 2/0", state, hold);
    end
    start_stop = 1'b0;
    lap_reset = 1'b0;
    tick(4);
    checks++;
    if (state !== PAUSE || hold !== 1'b0 || clear !== 1'b0) begin
      errors++;
      $display("FAIL lap_not_queued: got state=%0d hold=%b clear=%b, want 2/0/0", state, hold, clear);
    end
  endtask

  task automatic test_reset_mid_run();
    press_start();
    checks++;
    if (state !== RUN) begin
      errors++;
      $display("FAIL mid_setup_run: got state=%0d, want 1", state);
    end
    tick(2);
    start_stop = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if ({state, count, clear, hold, running} !== {IDLE, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset: got state=%0d count=%b clear=%b hold=%b running=%b, want 0 and all 0",
               state, count, clear, hold, running);
    end
    tick(8);
    checks++;
    if (state !== IDLE || clear !== 1'b0) begin
      errors++;
      $display("FAIL held_through_reset: got state=%0d clear=%b, want 0/0", state, clear);
    end
    start_stop = 1'b0;
    tick(3);
    press_start();
    checks++;
    if (state !== RUN) begin
      errors++;
      $display("FAIL repress_after_reset: got state=%0d, want 1", state);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checks++;
      if (count !== (k == 4)) begin
        errors++;
        $display("FAIL post_reset_tick k=%0d: got count=%b, want %b", k, count, k == 4);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start_stop = 1'b0;
    lap_reset = 1'b0;
    test_reset();
    test_start_hold();
    test_pause_resume();
    test_lap();
    test_clear();
    test_simultaneous();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
